// File: rtl/ps2_frame_rx_pkg.sv
// ps2_frame_rx_pkg
// Shared definitions for the PS/2 frame receiver: FSM state encoding,
// error-code constants and the odd-parity helper.
package ps2_frame_rx_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        CHECK   = 2'd2
    } ps2_state_t;

    // Values reported on oErrorCode
    localparam logic [1:0] PS2_ERR_PARITY  = 2'b01;
    localparam logic [1:0] PS2_ERR_FRAME   = 2'b10;
    localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b11;

    // Eight data bits plus the parity bit must XOR to 1 (odd parity)
    function automatic logic oddParityOk(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/enable_flop.sv
// enable_flop
// Generic register with load enable and asynchronous active-low reset.
// Ports:
//   Clock  - system clock, rising edge
//   Reset  - asynchronous active-low reset, loads RESET_VALUE
//   enable - load d into q on the next rising edge
//   d      - next value
//   q      - registered value
module enable_flop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold the value unless enabled; reset forces the configured value
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            q <= RESET_VALUE;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ps2_glitch_filter.sv
// ps2_glitch_filter
// Synchronizes the raw PS/2 clock and data pins and deglitches the clock.
// The filtered clock only changes level after the synchronized clock has
// held the opposite level for FILTER_LEN consecutive cycles.
// Ports:
//   Clock     - system clock, rising edge
//   Reset     - asynchronous active-low reset
//   ps2Clk    - raw PS/2 clock pin (asynchronous)
//   ps2Data   - raw PS/2 data pin (asynchronous)
//   filtClk   - deglitched PS/2 clock level
//   fallPulse - one-cycle pulse on the first cycle filtClk is low
//   syncData  - synchronized PS/2 data
module ps2_glitch_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic ps2Clk,
    input  logic ps2Data,
    output logic filtClk,
    output logic fallPulse,
    output logic syncData
);

    localparam int             CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    clkSync;
    logic [1:0]    dataSync;
    logic [CW-1:0] diffCnt;
    logic          syncClk;

    assign syncClk  = clkSync[1];
    assign syncData = dataSync[1];

    // Two-flop synchronizers; reset to 1 so an idle bus looks idle
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
        end else begin
            clkSync  <= {clkSync[0], ps2Clk};
            dataSync <= {dataSync[0], ps2Data};
        end
    end

    // Count consecutive cycles where the synchronized clock disagrees with
    // the filtered level; a single agreeing sample restarts the count, so
    // glitches shorter than FILTER_LEN cycles never reach filtClk.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            filtClk   <= 1'b1;
            diffCnt   <= '0;
            fallPulse <= 1'b0;
        end else begin
            fallPulse <= 1'b0;
            if (syncClk != filtClk) begin
                if (diffCnt == CNT_LAST) begin
                    filtClk   <= syncClk;
                    diffCnt   <= '0;
                    fallPulse <= ~syncClk;
                end else begin
                    diffCnt <= diffCnt + 1'b1;
                end
            end else begin
                diffCnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
// PS/2 device-to-host frame receiver. Shifts in 11-bit frames (start,
// 8 data LSB first, odd parity, stop) on falling edges of the filtered PS/2
// clock, checks them and presents good bytes with a one-cycle strobe.
// Ports:
//   Clock      - system clock, rising edge
//   Reset      - asynchronous active-low reset
//   iPS2_CLK   - raw PS/2 clock pin
//   iPS2_DATA  - raw PS/2 data pin
//   oData      - last correctly received byte
//   oValid     - one-cycle pulse, oData updated
//   oError     - one-cycle pulse, frame discarded
//   oErrorCode - cause of the last error (01 parity, 10 framing, 11 timeout)
//   oBusy      - a frame is in progress
module ps2_frame_rx
    import ps2_frame_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oError,
    output logic [1:0] oErrorCode,
    output logic       oBusy
);

    localparam int            TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          filtClk;
    logic          fallPulse;
    logic          syncData;
    logic          sampleEvent;

    ps2_state_t    state;
    logic [3:0]    bitCount;
    logic [9:0]    shiftReg;
    logic [TW-1:0] timeoutCnt;

    logic [9:0]    shiftNext;
    logic          stopSample;
    logic          timeoutHit;
    logic          parityOk;
    logic          stopOk;
    logic          validNext;
    logic          errorNext;
    logic [1:0]    codeNext;

    ps2_glitch_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .Clock    (Clock),
        .Reset    (Reset),
        .ps2Clk   (iPS2_CLK),
        .ps2Data  (iPS2_DATA),
        .filtClk  (filtClk),
        .fallPulse(fallPulse),
        .syncData (syncData)
    );

    assign sampleEvent = fallPulse & ~filtClk;

    // Frame verdict is formed on the stop-bit sample itself so the
    // registered strobes land in the CHECK cycle. shiftReg[0] holds the
    // start bit at that point and is re-checked as part of framing.
    always_comb begin
        shiftNext  = {syncData, shiftReg[9:1]};
        stopSample = (state == RECEIVE) && sampleEvent && (bitCount == 4'd10);
        timeoutHit = (state == RECEIVE) && !sampleEvent && (timeoutCnt == TIMEOUT_LAST);
        parityOk   = oddParityOk(shiftNext[8:0]);
        stopOk     = shiftNext[9] & ~shiftReg[0];
        validNext  = stopSample && parityOk && stopOk;
        errorNext  = (stopSample && !(parityOk && stopOk)) || timeoutHit;
        codeNext   = PS2_ERR_FRAME;
        if (timeoutHit) begin
            codeNext = PS2_ERR_TIMEOUT;
        end else if (!parityOk) begin
            codeNext = PS2_ERR_PARITY;
        end
    end

    // Receiver FSM. The start bit is loaded into the top of the shift
    // register; a sample event always takes priority over the timeout.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            bitCount   <= '0;
            shiftReg   <= '0;
            timeoutCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeoutCnt <= '0;
                    if (sampleEvent && !syncData) begin
                        state    <= RECEIVE;
                        bitCount <= 4'd1;
                        shiftReg <= {syncData, 9'b0};
                    end
                end
                RECEIVE: begin
                    if (sampleEvent) begin
                        shiftReg   <= shiftNext;
                        bitCount   <= bitCount + 4'd1;
                        timeoutCnt <= '0;
                        if (bitCount == 4'd10) begin
                            state <= CHECK;
                        end
                    end else if (timeoutCnt == TIMEOUT_LAST) begin
                        state      <= IDLE;
                        bitCount   <= '0;
                        shiftReg   <= '0;
                        timeoutCnt <= '0;
                    end else begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                    end
                end
                CHECK: begin
                    state      <= IDLE;
                    bitCount   <= '0;
                    shiftReg   <= '0;
                    timeoutCnt <= '0;
                end
                default: begin
                    state      <= IDLE;
                    bitCount   <= '0;
                    shiftReg   <= '0;
                    timeoutCnt <= '0;
                end
            endcase
        end
    end

    assign oBusy = (state != IDLE);

    // Byte register only loads on a good frame, so errors leave it intact
    enable_flop #(.WIDTH(8), .RESET_VALUE(8'h00)) u_data (
        .Clock (Clock),
        .Reset (Reset),
        .enable(validNext),
        .d     (shiftNext[7:0]),
        .q     (oData)
    );

    enable_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) u_valid (
        .Clock (Clock),
        .Reset (Reset),
        .enable(1'b1),
        .d     (validNext),
        .q     (oValid)
    );

    enable_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) u_error (
        .Clock (Clock),
        .Reset (Reset),
        .enable(1'b1),
        .d     (errorNext),
        .q     (oError)
    );

    // Error code is sticky until the next discarded frame
    enable_flop #(.WIDTH(2), .RESET_VALUE(2'b00)) u_code (
        .Clock (Clock),
        .Reset (Reset),
        .enable(errorNext),
        .d     (codeNext),
        .q     (oErrorCode)
    );

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx
// Self-checking bench for ps2_frame_rx: table of frames with expected
// results pushed to a scoreboard, plus hand-written glitch, timeout and
// mid-frame reset sequences.
module tb_ps2_frame_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 600;
    localparam int HALF       = 40;
    localparam int GAP        = 60;

    logic       Clock     = 1'b0;
    logic       Reset     = 1'b0;
    logic       iPS2_CLK  = 1'b1;
    logic       iPS2_DATA = 1'b1;
    logic [7:0] oData;
    logic       oValid;
    logic       oError;
    logic [1:0] oErrorCode;
    logic       oBusy;

    typedef struct {
        logic [7:0] data;
        bit         parFlip;
        bit         stopBit;
        bit         expValid;
        logic [1:0] expCode;
    } vec_t;

    typedef struct {
        bit         isValid;
        logic [7:0] data;
        logic [1:0] code;
    } sb_t;

    sb_t        sbQ[$];
    vec_t       vecs[7];
    int         checks       = 0;
    int         errors       = 0;
    int         cycleCnt     = 0;
    int         lastErrCycle = -1;
    int         lastFallCycle = 0;
    logic [7:0] lastData     = 8'h00;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iPS2_CLK  (iPS2_CLK),
        .iPS2_DATA (iPS2_DATA),
        .oData     (oData),
        .oValid    (oValid),
        .oError    (oError),
        .oErrorCode(oErrorCode),
        .oBusy     (oBusy)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cycleCnt++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every strobe must match the oldest pending expectation
    always @(negedge Clock) begin
        if (Reset === 1'b1 && (oValid !== 1'b0 || oError !== 1'b0)) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe: got valid=%b error=%b, expected none", oValid, oError);
            end else begin
                sb_t exp;
                exp = sbQ.pop_front();
                checkOutput("strobe_kind", {30'd0, oValid, oError}, exp.isValid ? 32'd2 : 32'd1);
                if (exp.isValid) begin
                    checkOutput("rx_data", oData, exp.data);
                end else begin
                    checkOutput("err_code", oErrorCode, exp.code);
                    checkOutput("data_held", oData, exp.data);
                    lastErrCycle = cycleCnt;
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    function automatic logic [10:0] buildFrame(input logic [7:0] d, input bit parFlip, input bit stopBit);
        logic par;
        par = ~(^d) ^ parFlip;
        return {stopBit, par, d, 1'b0};
    endfunction

    // One PS/2 bit: data set while clock high, then a low phase; an
    // optional 7-cycle clock glitch is placed in the high phase
    task automatic sendBit(input logic b, input bit glitch);
        iPS2_DATA = b;
        if (glitch) begin
            waitCycles(8);
            iPS2_CLK = 1'b0;
            waitCycles(7);
            iPS2_CLK = 1'b1;
            waitCycles(10);
        end else begin
            waitCycles(HALF / 2);
        end
        iPS2_CLK      = 1'b0;
        lastFallCycle = cycleCnt;
        waitCycles(HALF);
        iPS2_CLK = 1'b1;
        waitCycles(HALF / 2);
    endtask

    task automatic sendBits(input logic [10:0] frame, input int nBits, input int glitchBit);
        for (int i = 0; i < nBits; i++) begin
            sendBit(frame[i], i == glitchBit);
        end
        iPS2_DATA = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v, input int glitchBit);
        sb_t e;
        e.isValid = v.expValid;
        e.data    = v.expValid ? v.data : lastData;
        e.code    = v.expCode;
        sbQ.push_back(e);
        if (v.expValid) lastData = v.data;
        sendBits(buildFrame(v.data, v.parFlip, v.stopBit), 11, glitchBit);
        waitCycles(GAP);
        checkOutput("sb_pending", sbQ.size(), 32'd0);
        sbQ.delete();
        checkOutput("data_after", oData, lastData);
        checkOutput("busy_idle", oBusy, 1'b0);
    endtask

    initial begin
        int delta;
        sb_t e;
        vec_t g;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 2'b00};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 2'b01};
        vecs[2] = '{8'h1C, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[3] = '{8'h32, 1'b0, 1'b1, 1'b1, 2'b00};
        vecs[4] = '{8'hA5, 1'b1, 1'b0, 1'b0, 2'b01};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 2'b00};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b1, 2'b00};

        waitCycles(3);
        checkOutput("rst_data", oData, 8'h00);
        checkOutput("rst_valid", oValid, 1'b0);
        checkOutput("rst_error", oError, 1'b0);
        checkOutput("rst_code", oErrorCode, 2'b00);
        checkOutput("rst_busy", oBusy, 1'b0);
        Reset = 1'b1;
        waitCycles(5);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], -1);
        end

        $display("[TB] glitch during frame 0xF0");
        g = '{8'hF0, 1'b0, 1'b1, 1'b1, 2'b00};
        applyStimulus(g, 4);

        $display("[TB] stalled frame timeout");
        e.isValid = 1'b0;
        e.data    = lastData;
        e.code    = 2'b11;
        sbQ.push_back(e);
        lastErrCycle = -1;
        sendBits(buildFrame(8'h1C, 1'b0, 1'b1), 4, -1);
        checkOutput("busy_mid_frame", oBusy, 1'b1);
        waitCycles(TIMEOUT + 40);
        checkOutput("timeout_pending", sbQ.size(), 32'd0);
        sbQ.delete();
        checkOutput("busy_after_timeout", oBusy, 1'b0);
        delta = lastErrCycle - lastFallCycle;
        checks++;
        if (lastErrCycle < 0 || delta < TIMEOUT + FILTER_LEN + 2 || delta > TIMEOUT + FILTER_LEN + 4) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got %0d cycles, expected %0d +/-1", delta, TIMEOUT + FILTER_LEN + 3);
        end

        $display("[TB] reset mid-frame");
        sendBits(buildFrame(8'h55, 1'b0, 1'b1), 6, -1);
        Reset = 1'b0;
        waitCycles(3);
        checkOutput("rst_mid_busy", oBusy, 1'b0);
        checkOutput("rst_mid_data", oData, 8'h00);
        Reset    = 1'b1;
        lastData = 8'h00;
        waitCycles(GAP);
        applyStimulus(vecs[0], -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
